// File: rtl/params_pkg.sv
// Shared widths, state encoding and types for the instruction fetch front end.
package params_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int PC_INCR    = 4;

    typedef logic [DATA_WIDTH-1:0] instruction_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {pc, instruction} skid register used when a response lands while
// decode is stalled on a valid output.
module fetch_hold_buffer #(
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [ADDR_WIDTH-1:0]    pc_i,
    input  params_pkg::instruction_t instr_i,
    output logic                     valid_o,
    output logic [ADDR_WIDTH-1:0]    pc_o,
    output params_pkg::instruction_t instr_o
);
    import params_pkg::*;

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    instruction_t          instr_q, instr_d;

    // Flush wins over a simultaneous push so a redirect never leaves stale data.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (push_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, keeps one imem read in flight and
// presents {valid, pc, instruction} to decode, with stall and redirect support.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     branch_taken_i,
    input  logic                     is_jump_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
    output logic                     imem_req_o,
    output logic [ADDR_WIDTH-1:0]    imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
    output logic                     valid_o,
    output logic [ADDR_WIDTH-1:0]    pc_o,
    output params_pkg::instruction_t instruction_o
);
    import params_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INCR);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  drop_q, drop_d;
    logic                  req_en_q, req_en_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    instruction_t          instr_q, instr_d;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  req;
    logic                  gnt;
    logic                  out_free;
    instruction_t          rdata;

    logic                  hold_push, hold_pop, hold_flush;
    logic                  hold_valid;
    logic [ADDR_WIDTH-1:0] hold_pc;
    instruction_t          hold_instr;

    assign redirect    = branch_taken_i | is_jump_i;
    assign redirect_pc = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    // req_en_q keeps the request low for the first cycle out of reset.
    assign req         = req_en_q && (state_q == S_REQ);
    assign gnt         = req && imem_gnt_i;
    assign out_free    = !stall_i || !valid_q;
    assign rdata       = instruction_t'(imem_rdata_i);

    fetch_hold_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hold_push),
        .pop_i   (hold_pop),
        .flush_i (hold_flush),
        .pc_i    (req_pc_q),
        .instr_i (rdata),
        .valid_o (hold_valid),
        .pc_o    (hold_pc),
        .instr_o (hold_instr)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        req_en_d   = 1'b1;
        valid_d    = valid_q;
        pc_out_d   = pc_out_q;
        instr_d    = instr_q;
        hold_push  = 1'b0;
        hold_pop   = 1'b0;
        hold_flush = 1'b0;

        // A consumed instruction with nothing behind it leaves a bubble.
        if (!stall_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (gnt) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (out_free) begin
                        valid_d  = 1'b1;
                        pc_out_d = req_pc_q;
                        instr_d  = rdata;
                    end else begin
                        hold_push = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i && hold_valid) begin
                    hold_pop = 1'b1;
                    valid_d  = 1'b1;
                    pc_out_d = hold_pc;
                    instr_d  = hold_instr;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides stall and every transition above.
        if (redirect) begin
            valid_d    = 1'b0;
            pc_out_d   = pc_out_q;
            instr_d    = instr_q;
            pc_d       = redirect_pc;
            hold_push  = 1'b0;
            hold_pop   = 1'b0;
            hold_flush = 1'b1;
            case (state_q)
                S_REQ: begin
                    if (gnt) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
            req_en_q <= 1'b0;
            valid_q  <= 1'b0;
            pc_out_q <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            req_en_q <= req_en_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign valid_o       = valid_q;
    assign pc_o          = pc_out_q;
    assign instruction_o = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic
// checked against an in-order instruction-stream reference model.
module tb_fetch_stage;
    import params_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          br;
    logic          jmp;
    logic [AW-1:0] rpc;
    logic          req;
    logic [AW-1:0] addr;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          valid;
    logic [AW-1:0] pc;
    instruction_t  instr;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   ('0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .branch_taken_i (br),
        .is_jump_i      (jmp),
        .redirect_pc_i  (rpc),
        .imem_req_o     (req),
        .imem_addr_o    (addr),
        .imem_gnt_i     (gnt),
        .imem_rvalid_i  (rvalid),
        .imem_rdata_i   (rdata),
        .valid_o        (valid),
        .pc_o           (pc),
        .instruction_o  (instr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: word at address a; address 0 holds 0x00500093.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h0100_0193);
    endfunction

    // Reference model: decode must see consecutive PCs, restarting at each redirect target.
    logic [31:0] exp_pc;
    logic [31:0] oq_addr[$];
    int          oq_lat[$];
    bit          prev_hold;
    bit          prev_redir;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    int          n_cons  = 0;
    int          max_lat = 0;

    task automatic monitor();
        if (rst) begin
            chk("rst_valid", valid, 0);
            chk("rst_pc", pc, 0);
            chk("rst_instr", instr, 0);
            chk("rst_req", req, 0);
            exp_pc = '0;
            oq_addr.delete();
            oq_lat.delete();
            prev_hold  = 1'b0;
            prev_redir = 1'b0;
            return;
        end
        if (prev_hold) begin
            chk("stall_valid", valid, 1);
            chk("stall_pc", pc, prev_pc);
            chk("stall_instr", instr, prev_instr);
        end
        if (prev_redir) chk("redir_squash", valid, 0);
        if (req) chk("addr_align", addr[1:0], 0);
        if (req && gnt) chk("one_outstanding", oq_addr.size(), 0);
        if (valid && !stall) begin
            chk("seq_pc", pc, exp_pc);
            chk("seq_instr", instr, memf(pc));
            exp_pc = exp_pc + 32'd4;
            n_cons++;
        end
        if (rvalid && oq_addr.size() > 0) begin
            void'(oq_addr.pop_front());
            void'(oq_lat.pop_front());
        end
        if (req && gnt) begin
            oq_addr.push_back(addr);
            oq_lat.push_back((max_lat == 0) ? 0 : int'($urandom_range(0, max_lat)));
        end
        if (br || jmp) exp_pc = {rpc[31:2], 2'b00};
        prev_hold  = valid && stall && !(br || jmp);
        prev_redir = br || jmp;
        prev_pc    = pc;
        prev_instr = instr;
    endtask

    task automatic imem_drive();
        rvalid = 1'b0;
        rdata  = $urandom();
        if (oq_addr.size() > 0) begin
            if (oq_lat[0] == 0) begin
                rvalid = 1'b1;
                rdata  = memf(oq_addr[0]);
            end else begin
                oq_lat[0] = oq_lat[0] - 1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        imem_drive();
    endtask

    task automatic wait_req(input logic [31:0] a, input string tag);
        int n = 0;
        while (!(req && addr == a) && n < 40) begin
            step();
            n++;
        end
        chk(tag, (req && addr == a), 1);
    endtask

    task automatic wait_out(input logic [31:0] a, input string tag);
        int n = 0;
        while (!(valid && pc == a) && n < 40) begin
            step();
            n++;
        end
        chk(tag, (valid && pc == a), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b1; stall = 1'b0; br = 1'b0; jmp = 1'b0; rpc = '0;
        gnt = 1'b1; rvalid = 1'b0; rdata = '0;
        exp_pc = '0; prev_hold = 1'b0; prev_redir = 1'b0;
        prev_pc = '0; prev_instr = '0;
        @(posedge clk); #1;
        repeat (3) step();

        // 1: first fetch, one-cycle memory
        rst = 1'b0;
        chk("t1_no_req_at_release", req, 0);
        step();
        chk("t1_req", req, 1);
        chk("t1_addr0", addr, 0);
        step();
        chk("t1_wait_valid", valid, 0);
        step();
        chk("t1_valid", valid, 1);
        chk("t1_pc0", pc, 0);
        chk("t1_instr", instr, 32'h0050_0093);
        step();
        step();
        chk("t1_valid4", valid, 1);
        chk("t1_pc4", pc, 4);

        // 2: stall with pc 0x8 on the output
        wait_out(32'h8, "t2_reach8");
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_valid", valid, 1);
            chk("t2_hold_pc", pc, 32'h8);
            if (i >= 2) chk("t2_no_req_in_hold", req, 0);
            step();
        end
        stall = 1'b0;
        chk("t2_release_pc", pc, 32'h8);
        chk("t2_release_no_req", req, 0);
        step();
        chk("t2_emit_valid", valid, 1);
        chk("t2_emit_pc", pc, 32'hC);

        // 3: redirect coincident with gnt
        wait_req(32'h10, "t3_reach10");
        br = 1'b1; rpc = 32'h40;
        step();
        br = 1'b0;
        chk("t3_squash_valid", valid, 0);
        chk("t3_no_req_drop", req, 0);
        step();
        chk("t3_drop_valid", valid, 0);
        chk("t3_req40", req, 1);
        chk("t3_addr40", addr, 32'h40);
        wait_out(32'h40, "t3_out40");

        // 4: redirect while parked in the hold buffer
        stall = 1'b1;
        step();
        step();
        chk("t4_no_req_hold", req, 0);
        chk("t4_hold_pc", pc, 32'h40);
        jmp = 1'b1; rpc = 32'h83;
        step();
        jmp = 1'b0;
        chk("t4_squash_valid", valid, 0);
        chk("t4_req80", req, 1);
        chk("t4_addr80", addr, 32'h80);
        stall = 1'b0;
        wait_out(32'h80, "t4_out80");

        // 5: grant withheld
        gnt = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t5_req", req, 1);
            chk("t5_addr", addr, 32'h84);
            chk("t5_no_valid", valid, 0);
            step();
        end
        gnt = 1'b1;

        // 6: reset while waiting, stray rvalid afterwards
        wait_req(32'h84, "t6_reach84");
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", valid, 0);
        chk("t6_async_pc", pc, 0);
        chk("t6_async_instr", instr, 0);
        chk("t6_async_req", req, 0);
        step();
        rst = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        step();
        chk("t6_stray_ignored", valid, 0);
        chk("t6_req_reset_pc", req, 1);
        chk("t6_addr_reset_pc", addr, 0);
        wait_out(32'h0, "t6_out0");

        // Wrap of pc+4, both redirect bits at once, low target bits ignored
        br = 1'b1; jmp = 1'b1; rpc = 32'hFFFF_FFFA;
        step();
        br = 1'b0; jmp = 1'b0;
        wait_out(32'hFFFF_FFF8, "wrap_fff8");
        wait_out(32'hFFFF_FFFC, "wrap_fffc");
        wait_out(32'h0, "wrap_0");

        // Random traffic
        max_lat = 3;
        for (int i = 0; i < 3000; i++) begin
            gnt   = ($urandom_range(0, 9) < 7);
            stall = ($urandom_range(0, 9) < 3);
            r     = int'($urandom_range(0, 31));
            br    = (r == 0) || (r == 2);
            jmp   = (r == 1) || (r == 2);
            rpc   = $urandom() & 32'h0000_03FF;
            step();
        end
        br = 1'b0; jmp = 1'b0; stall = 1'b0;
        chk("progress", (n_cons > 150), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
